fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FFT_LEN, default 1024: samples per frame, power of two, 8..65536.
REQ-002 SHALL have parameter IDX_W, default 10: width of sample_idx, log2(FFT_LEN).
REQ-003 SHALL have parameter GAP_CYC, default 16: idle cycles between frames in continuous mode, 0 allowed.
REQ-004 SHALL have parameter TMO_CYC, default 65535: maximum DRAIN wait for FFT output eop.
REQ-005 SHALL have ports:
  clk  in  1  single clock
  rst_n  in  1  asynchronous active-low reset
  start  in  1  pulse, begin frame sequence
  cont  in  1  1 = repeat frames until abort
  abort  in  1  pulse, stop immediately
  sink_ready  in  1  FFT accepts input sample
  sink_valid  out  1  sample offered to FFT
  sink_sop  out  1  first sample of frame
  sink_eop  out  1  last sample of frame
  sink_error  out  2  tied 2'b00
  sample_idx  out  IDX_W  index of sample offered (sample-buffer read address)
  source_valid  in  1  FFT output valid
  source_eop  in  1  FFT output last bin
  busy  out  1  state != IDLE
  frame_done  out  1  one-cycle pulse, frame output complete
  frame_cnt  out  16  completed frames
  tmo_err  out  1  sticky DRAIN timeout flag

Function
REQ-006 SHALL implement states IDLE, FEED, DRAIN, GAP.
REQ-007 SHALL, in IDLE, on start with abort low, load sample_idx=0, clear tmo_err and enter FEED on the next edge; start in any other state SHALL be ignored.
REQ-008 SHALL drive sink_valid=1 throughout FEED and 0 in all other states.
REQ-009 SHALL drive sink_sop = FEED & sample_idx==0, and sink_eop = FEED & sample_idx==FFT_LEN-1, both decoded from registered state/index only.
REQ-010 SHALL define transfer = sink_valid & sink_ready; sample_idx SHALL increment only on transfer, and sink_valid/sop/eop/sample_idx SHALL hold stable while sink_ready=0.
REQ-011 SHALL, on transfer at sample_idx==FFT_LEN-1, wrap sample_idx to 0 and enter DRAIN.
REQ-012 SHALL, in DRAIN, on source_valid & source_eop pulse frame_done for one cycle, increment frame_cnt (wrap 16'hFFFF->0), then go to GAP if cont=1 and GAP_CYC>0, FEED if cont=1 and GAP_CYC==0, else IDLE; cont is sampled on that cycle only.
REQ-013 SHALL, in GAP, wait exactly GAP_CYC cycles then enter FEED with sample_idx=0.
REQ-014 SHALL, after TMO_CYC DRAIN cycles without output eop, set tmo_err and enter IDLE without frame_done or frame_cnt change.
REQ-015 SHALL, on abort in any state, enter IDLE on the next edge, sample_idx=0; abort SHALL override start and a same-cycle source eop (no frame_done, no count).
REQ-016 SHALL ignore source_valid/source_eop outside DRAIN.

Reset
REQ-017 SHALL, on rst_n low, asynchronously force state IDLE, sample_idx 0, frame_cnt 0, tmo_err 0, frame_done 0, hence sink_valid/sop/eop 0 and busy 0.
REQ-018 SHALL resume only from IDLE after reset release; a frame in progress at reset is discarded.

Structure
REQ-019 SHALL place the state encoding and default FFT_LEN/GAP_CYC/TMO_CYC constants in shared package fft_ctrl_pkg.
REQ-020 SHALL use one sub-module fft_ctrl_timer (loadable down-counter with zero flag) shared by GAP and DRAIN timeout.

Verification (FFT_LEN=8, GAP_CYC=2, TMO_CYC=20)
REQ-021 Single frame, sink_ready=1: start -> sink_valid 8 cycles, sop at idx 0, eop at idx 7; FFT model eop -> frame_done 1 cycle, frame_cnt=1, busy=0.
REQ-022 Backpressure: sink_ready low at idx 3 for 4 cycles -> idx/sop/eop held, exactly 8 transfers total.
REQ-023 Continuous: cont=1, 3 frames -> 2 idle cycles between output eop and next sop, frame_cnt=3; cont=0 before 3rd eop -> IDLE.
REQ-024 Abort at idx 5 and same-cycle start -> IDLE next cycle, sink_valid=0, frame_cnt unchanged, no restart.
REQ-025 No source_eop -> tmo_err=1 after 20 DRAIN cycles, IDLE; next start clears tmo_err.
REQ-026 rst_n low mid-FEED -> all outputs 0 asynchronously; frame_cnt 16'hFFFF + one frame -> 0.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared state encoding and default constants for the FFT frame controller
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } fft_state_t;

    localparam int DEF_FFT_LEN = 1024;
    localparam int DEF_IDX_W   = 10;
    localparam int DEF_GAP_CYC = 16;
    localparam int DEF_TMO_CYC = 65535;

    // Bits needed to hold a down-counter load value of max_val, never below one.
    function automatic int tmr_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fft_ctrl_timer.sv
// rtl/fft_ctrl_timer.sv - loadable down-counter with zero flag, shared by GAP wait and DRAIN timeout
module fft_ctrl_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer feeding samples to an FFT core and tracking its output frames
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_LEN = DEF_FFT_LEN,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             sink_ready,
    output logic             sink_valid,
    output logic             sink_sop,
    output logic             sink_eop,
    output logic [1:0]       sink_error,
    output logic [IDX_W-1:0] sample_idx,
    input  logic             source_valid,
    input  logic             source_eop,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             tmo_err
);

    localparam int TMR_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
    localparam int TMR_W   = tmr_width(TMR_MAX);
    localparam bit HAS_GAP = (GAP_CYC > 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
    // Loading N-1 makes the state last N cycles: the zero flag is seen on the Nth.
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = HAS_GAP ? TMR_W'(GAP_CYC - 1) : '0;

    fft_state_t       state;
    logic             transfer;
    logic             out_eop;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;

    assign sink_valid = (state == ST_FEED);
    assign sink_sop   = sink_valid && (sample_idx == '0);
    assign sink_eop   = sink_valid && (sample_idx == LAST_IDX);
    assign sink_error = 2'b00;
    assign busy       = (state != ST_IDLE);
    assign transfer   = sink_valid && sink_ready;
    assign out_eop    = source_valid && source_eop;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state)
            ST_FEED: begin
                if (transfer && (sample_idx == LAST_IDX)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_eop) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GAP:  tmr_en = 1'b1;
            default: ;
        endcase
    end

    fft_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sample_idx <= '0;
            frame_cnt  <= '0;
            tmo_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state      <= ST_IDLE;
                sample_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            sample_idx <= '0;
                            tmo_err    <= 1'b0;
                            state      <= ST_FEED;
                        end
                    end
                    ST_FEED: begin
                        if (transfer) begin
                            if (sample_idx == LAST_IDX) begin
                                sample_idx <= '0;
                                state      <= ST_DRAIN;
                            end else begin
                                sample_idx <= sample_idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_eop) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            if (!cont)
                                state <= ST_IDLE;
                            else if (HAS_GAP)
                                state <= ST_GAP;
                            else
                                state <= ST_FEED;
                        end else if (tmr_zero) begin
                            tmo_err <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (tmr_zero) begin
                            sample_idx <= '0;
                            state      <= ST_FEED;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed self-checking bench for fft_frame_ctrl (FFT_LEN=8, GAP_CYC=2, TMO_CYC=20)
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cont, abort, sink_ready;
    logic        source_valid, source_eop;
    logic        sink_valid, sink_sop, sink_eop, busy, frame_done, tmo_err;
    logic [1:0]  sink_error;
    logic [2:0]  sample_idx;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int xfers;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .FFT_LEN (8),
        .IDX_W   (3),
        .GAP_CYC (2),
        .TMO_CYC (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .abort        (abort),
        .sink_ready   (sink_ready),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_error   (sink_error),
        .sample_idx   (sample_idx),
        .source_valid (source_valid),
        .source_eop   (source_eop),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .tmo_err      (tmo_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_frame(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_valid"}, 32'(sink_valid), 32'd1);
            chk({tag, "_idx"}, 32'(sample_idx), 32'(i));
            chk({tag, "_sop"}, 32'(sink_sop), 32'(i == 0));
            chk({tag, "_eop"}, 32'(sink_eop), 32'(i == 7));
            tick();
        end
    endtask

    task automatic out_eop_pulse();
        source_valid = 1'b1;
        source_eop   = 1'b1;
        tick();
        source_valid = 1'b0;
        source_eop   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        sink_ready = 1'b1; source_valid = 1'b0; source_eop = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(sink_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_tmo", 32'(tmo_err), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(sink_error), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // single frame, no backpressure
        start_frame();
        feed_frame("f1");
        chk("f1_drain_valid", 32'(sink_valid), 32'd0);
        chk("f1_drain_busy", 32'(busy), 32'd1);
        out_eop_pulse();
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_busy", 32'(busy), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(frame_done), 32'd0);

        // backpressure at idx 3 for 4 cycles
        xfers = 0;
        start_frame();
        for (int i = 0; i < 3; i++) begin
            chk("bp_idx_pre", 32'(sample_idx), 32'(i));
            if (sink_valid && sink_ready) xfers++;
            tick();
        end
        sink_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_idx", 32'(sample_idx), 32'd3);
            chk("bp_hold_valid", 32'(sink_valid), 32'd1);
            chk("bp_hold_sop", 32'(sink_sop), 32'd0);
            chk("bp_hold_eop", 32'(sink_eop), 32'd0);
            tick();
        end
        sink_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            chk("bp_idx_post", 32'(sample_idx), 32'(i));
            chk("bp_eop", 32'(sink_eop), 32'(i == 7));
            if (sink_valid && sink_ready) xfers++;
            tick();
        end
        chk("bp_xfers", 32'(xfers), 32'd8);
        chk("bp_drain_valid", 32'(sink_valid), 32'd0);
        out_eop_pulse();
        chk("bp_cnt", 32'(frame_cnt), 32'd2);

        // continuous mode, three frames with two-cycle gap
        cont = 1'b1;
        start_frame();
        for (int f = 0; f < 3; f++) begin
            if (f == 2) cont = 1'b0;
            feed_frame("ct");
            tick();
            tick();
            chk("ct_drain_busy", 32'(busy), 32'd1);
            out_eop_pulse();
            chk("ct_done", 32'(frame_done), 32'd1);
            chk("ct_cnt", 32'(frame_cnt), 32'(3 + f));
            if (f < 2) begin
                chk("ct_gap1_valid", 32'(sink_valid), 32'd0);
                chk("ct_gap1_busy", 32'(busy), 32'd1);
                tick();
                chk("ct_gap2_valid", 32'(sink_valid), 32'd0);
                tick();
                chk("ct_next_sop", 32'(sink_sop), 32'd1);
            end else begin
                chk("ct_end_busy", 32'(busy), 32'd0);
                tick();
                chk("ct_end_valid", 32'(sink_valid), 32'd0);
            end
        end

        // abort at idx 5 with simultaneous start
        start_frame();
        for (int i = 0; i < 5; i++) tick();
        chk("ab_idx5", 32'(sample_idx), 32'd5);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(sink_valid), 32'd0);
        chk("ab_idx", 32'(sample_idx), 32'd0);
        chk("ab_cnt", 32'(frame_cnt), 32'd5);
        tick();
        chk("ab_norestart", 32'(busy), 32'd0);

        // abort wins over a same-cycle output eop in DRAIN
        start_frame();
        for (int i = 0; i < 8; i++) tick();
        abort = 1'b1;
        source_valid = 1'b1;
        source_eop = 1'b1;
        tick();
        abort = 1'b0;
        source_valid = 1'b0;
        source_eop = 1'b0;
        chk("abe_done", 32'(frame_done), 32'd0);
        chk("abe_cnt", 32'(frame_cnt), 32'd5);
        chk("abe_busy", 32'(busy), 32'd0);

        // DRAIN timeout after 20 cycles
        start_frame();
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 19; i++) tick();
        chk("tmo_last_busy", 32'(busy), 32'd1);
        chk("tmo_last_err", 32'(tmo_err), 32'd0);
        tick();
        chk("tmo_err", 32'(tmo_err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_done", 32'(frame_done), 32'd0);
        chk("tmo_cnt", 32'(frame_cnt), 32'd5);
        out_eop_pulse();
        chk("idle_eop_done", 32'(frame_done), 32'd0);
        chk("idle_eop_cnt", 32'(frame_cnt), 32'd5);
        start_frame();
        chk("tmo_clear", 32'(tmo_err), 32'd0);
        chk("tmo_restart", 32'(busy), 32'd1);

        // asynchronous reset mid-FEED
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(sink_valid), 32'd0);
        chk("arst_sop", 32'(sink_sop), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_idx", 32'(sample_idx), 32'd0);
        chk("arst_cnt", 32'(frame_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_noresume", 32'(busy), 32'd0);

        // frame counter wrap from 16'hFFFF
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        #1;
        chk("wrap_pre", 32'(frame_cnt), 32'hFFFF);
        tick();
        start_frame();
        for (int i = 0; i < 8; i++) tick();
        out_eop_pulse();
        chk("wrap_done", 32'(frame_done), 32'd1);
        chk("wrap_cnt", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
